// File: rtl/audio_sample_feeder.sv
// UART-fed audio sample FIFO with a fixed-rate pacer and a prime/run playback gate.
// Define AUDIO_SAMPLE_FEEDER_PARITY_EN for 8E1 frames; default build receives 8N1.
module audio_sample_feeder #(
  parameter int BAUD_DIV   = 250,
  parameter int SAMPLE_DIV = 5669,
  parameter int FIFO_AW    = 6
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_rx,
  output logic [7:0]         o_sample,
  output logic               o_sample_stb,
  output logic [FIFO_AW:0]   o_level,
  output logic               o_underrun,
  output logic               o_overrun,
  output logic               o_frame_err
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int BW    = $clog2(BAUD_DIV);
  localparam int SW    = $clog2(SAMPLE_DIV);
  localparam int LW    = FIFO_AW + 1;

  localparam logic [BW-1:0] BIT_LAST  = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
  localparam logic [SW-1:0] TICK_LAST = SW'(SAMPLE_DIV - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_PRIME = LW'(DEPTH / 2);

  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
  localparam logic [2:0] RX_STOP   = 3'd4;
`ifdef AUDIO_SAMPLE_FEEDER_PARITY_EN
  localparam logic [2:0] RX_PARITY = 3'd3;
  localparam logic [2:0] RX_POST   = RX_PARITY;
`else
  localparam logic [2:0] RX_POST   = RX_STOP;
`endif

  localparam logic [0:0] PC_PRIME = 1'b0;
  localparam logic [0:0] PC_RUN   = 1'b1;

  logic            rx_meta, rx_sync, rx_prev;
  logic            rx_fall;
  logic [2:0]      rx_state;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      rx_shift;
  logic            push_req;
  logic            bit_last;
  logic            bit_smp;
  logic            stop_ok;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [SW-1:0]      pace_cnt;
  logic [0:0]         pace_state;
  logic               tick, pop, push_ok;

  assign rx_fall  = rx_prev & ~rx_sync;
  assign bit_last = (baud_cnt == BIT_LAST);
  assign bit_smp  = (rx_state == RX_DATA) && bit_last;

`ifdef AUDIO_SAMPLE_FEEDER_PARITY_EN
  logic par_err;
  assign stop_ok = rx_sync & ~par_err;
`else
  assign stop_ok = rx_sync;
`endif

  // Line synchronizer; rx_prev gives the falling-edge reference.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_state    <= RX_IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      push_req    <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef AUDIO_SAMPLE_FEEDER_PARITY_EN
      par_err     <= 1'b0;
`endif
    end else begin
      push_req    <= 1'b0;
      o_frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state <= RX_START;
            baud_cnt <= '0;
          end
        end
        RX_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        RX_DATA: begin
          if (bit_last) begin
            baud_cnt <= '0;
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= RX_POST;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
`ifdef AUDIO_SAMPLE_FEEDER_PARITY_EN
        RX_PARITY: begin
          if (bit_last) begin
            baud_cnt <= '0;
            par_err  <= ^{rx_shift, rx_sync};
            rx_state <= RX_STOP;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
`endif
        RX_STOP: begin
          // Byte is pushed the cycle after a good stop sample.
          if (bit_last) begin
            baud_cnt <= '0;
            rx_state <= RX_IDLE;
            if (stop_ok) push_req <= 1'b1;
            else         o_frame_err <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (bit_smp) rx_shift <= {rx_sync, rx_shift[7:1]};
  end

  assign tick    = (pace_cnt == TICK_LAST);
  assign pop     = (pace_state == PC_RUN) && tick && (o_level != '0);
  assign push_ok = push_req && ((o_level != LVL_FULL) || pop);

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= rx_shift;
  end

  // FIFO pointers/occupancy and the prime/run pacer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_level      <= '0;
      pace_cnt     <= '0;
      pace_state   <= PC_PRIME;
      o_sample     <= 8'h80;
      o_sample_stb <= 1'b0;
      o_underrun   <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_sample_stb <= 1'b0;
      o_underrun   <= 1'b0;
      o_overrun    <= push_req && !push_ok;
      pace_cnt     <= tick ? '0 : pace_cnt + SW'(1);
      if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push_ok, pop})
        2'b10:   o_level <= o_level + LW'(1);
        2'b01:   o_level <= o_level - LW'(1);
        default: o_level <= o_level;
      endcase
      if (pace_state == PC_PRIME) begin
        if (o_level >= LVL_PRIME) pace_state <= PC_RUN;
      end else if (tick) begin
        if (pop) begin
          o_sample     <= mem[rd_ptr];
          o_sample_stb <= 1'b1;
        end else begin
          o_underrun <= 1'b1;
          o_sample   <= 8'h80;
          pace_state <= PC_PRIME;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Bench for audio_sample_feeder: directed frame table, priming/underrun/overrun/reset
// sequences, and randomized traffic checked every cycle against a queue-based model.
module tb_audio_sample_feeder;
  localparam int BAUD  = 16;
  localparam int SDIV  = 400;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int HALF  = 4;
`ifdef AUDIO_SAMPLE_FEEDER_PARITY_EN
  localparam int PUSH_OFS = 172;
  localparam bit PAR      = 1'b1;
  localparam int NT       = 6;
`else
  localparam int PUSH_OFS = 156;
  localparam bit PAR      = 1'b0;
  localparam int NT       = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [7:0]  o_sample;
  logic        o_sample_stb;
  logic [AW:0] o_level;
  logic        o_underrun, o_overrun, o_frame_err;

  audio_sample_feeder #(.BAUD_DIV(BAUD), .SAMPLE_DIV(SDIV), .FIFO_AW(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx),
    .o_sample(o_sample), .o_sample_stb(o_sample_stb), .o_level(o_level),
    .o_underrun(o_underrun), .o_overrun(o_overrun), .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; sample ticks land on multiples of SDIV.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int nvec = 0;
  int nerr = 0;

  int         ev_cyc  [256];
  logic [7:0] ev_d    [256];
  bit         ev_good [256];
  int         ev_wr = 0;
  int         ev_rd = 0;

  logic [7:0] mq[$];
  bit         m_run = 1'b0;
  logic [7:0] m_sample = 8'h80;
  int         m_ovr = 0;

  logic [7:0] stb_log[$];
  int und_cnt = 0, ovr_cnt = 0, ferr_cnt = 0, max_lvl = 0;

  typedef struct {
    logic [7:0] d;
    bit         stop_b;
    bit         pflip;
    bit         glitch;
    bit         e_ferr;
    int         e_lvl;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic rst_check();
    chk("rst_level", o_level, 0);
    chk("rst_sample", o_sample, 8'h80);
    chk("rst_pulses", {o_sample_stb, o_underrun, o_overrun, o_frame_err}, 4'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rst_check();
    step(3);
    rst_n = 1'b1;
  endtask

  // Called just after a clock edge; the frame's push (or error) cycle is posted for the model.
  task automatic send_frame(input logic [7:0] d, input bit stop_b, input bit pflip);
    ev_cyc[ev_wr]  = cyc + PUSH_OFS;
    ev_d[ev_wr]    = d;
    ev_good[ev_wr] = stop_b && !pflip;
    ev_wr++;
    rx = 1'b0;
    step(BAUD);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      step(BAUD);
    end
    if (PAR) begin
      rx = (^d) ^ pflip;
      step(BAUD);
    end
    rx = stop_b;
    step(BAUD);
    rx = 1'b1;
    if (!stop_b) step(BAUD);
  endtask

  task automatic glitch();
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    step(24);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
        m_run    = 1'b0;
        m_sample = 8'h80;
        ev_rd    = ev_wr;
      end else begin
        bit         tick, e_stb, e_und, e_ovr, e_ferr, pushv, popd;
        logic [7:0] pd;
        int         lvl;
        tick  = (cyc != 0) && (cyc % SDIV == 0);
        e_stb = 0; e_und = 0; e_ovr = 0; e_ferr = 0; pushv = 0; popd = 0;
        pd    = 8'h00;
        lvl   = mq.size();
        if (ev_rd != ev_wr) begin
          if (!ev_good[ev_rd] && cyc == ev_cyc[ev_rd] - 1) begin
            e_ferr = 1; ev_rd++;
          end else if (ev_good[ev_rd] && cyc == ev_cyc[ev_rd]) begin
            pushv = 1; pd = ev_d[ev_rd]; ev_rd++;
          end
        end
        if (m_run) begin
          if (tick) begin
            if (lvl > 0) begin
              m_sample = mq.pop_front();
              e_stb = 1; popd = 1;
            end else begin
              e_und = 1; m_sample = 8'h80; m_run = 1'b0;
            end
          end
        end else if (lvl >= HALF) begin
          m_run = 1'b1;
        end
        if (pushv) begin
          if (lvl < DEPTH || popd) mq.push_back(pd);
          else begin
            e_ovr = 1; m_ovr++;
          end
        end
        chk("level", o_level, mq.size());
        chk("sample", o_sample, m_sample);
        chk("pulses stb/und/ovr/ferr", {o_sample_stb, o_underrun, o_overrun, o_frame_err},
            {e_stb, e_und, e_ovr, e_ferr});
        if (o_sample_stb) stb_log.push_back(o_sample);
        und_cnt  += int'(o_underrun);
        ovr_cnt  += int'(o_overrun);
        ferr_cnt += int'(o_frame_err);
        if (int'(o_level) > max_lvl) max_lvl = int'(o_level);
      end
    end
  endtask

  initial begin
    vec_t       tbl [NT];
    int         s0, u0, f0;
    logic [7:0] prime_exp [4];

    tbl[0] = '{d: 8'h3C, stop_b: 1, pflip: 0, glitch: 0, e_ferr: 0, e_lvl: 1};
    tbl[1] = '{d: 8'h77, stop_b: 0, pflip: 0, glitch: 0, e_ferr: 1, e_lvl: 1};
    tbl[2] = '{d: 8'h00, stop_b: 1, pflip: 0, glitch: 1, e_ferr: 0, e_lvl: 1};
    tbl[3] = '{d: 8'hC3, stop_b: 1, pflip: 0, glitch: 0, e_ferr: 0, e_lvl: 2};
`ifdef AUDIO_SAMPLE_FEEDER_PARITY_EN
    tbl[4] = '{d: 8'hA5, stop_b: 1, pflip: 0, glitch: 0, e_ferr: 0, e_lvl: 3};
    tbl[5] = '{d: 8'hA5, stop_b: 1, pflip: 1, glitch: 0, e_ferr: 1, e_lvl: 3};
`endif
    prime_exp[0] = 8'h00; prime_exp[1] = 8'h11; prime_exp[2] = 8'h22; prime_exp[3] = 8'h33;

    fork
      monitor();
    join_none

    @(posedge clk);
    #2;
    do_reset();

    for (int i = 0; i < NT; i++) begin
      f0 = ferr_cnt;
      if (tbl[i].glitch) glitch();
      else               send_frame(tbl[i].d, tbl[i].stop_b, tbl[i].pflip);
      step(4);
      chk($sformatf("tbl%0d_frame_err", i), ferr_cnt - f0, tbl[i].e_ferr);
      chk($sformatf("tbl%0d_level", i), o_level, tbl[i].e_lvl);
    end

    // Priming then underrun.
    do_reset();
    s0 = stb_log.size();
    u0 = und_cnt;
    for (int i = 0; i < 4; i++) send_frame(prime_exp[i], 1'b1, 1'b0);
    for (int t = 0; t < 4000 && und_cnt == u0; t++) step(1);
    chk("prime_underrun_count", und_cnt - u0, 1);
    chk("prime_stb_count", stb_log.size() - s0, 4);
    for (int j = 0; j < 4; j++)
      if (stb_log.size() > s0 + j) chk($sformatf("prime_byte%0d", j), stb_log[s0 + j], prime_exp[j]);
    chk("underrun_sample", o_sample, 8'h80);

    // Overrun: outpace the pacer until the FIFO saturates.
    do_reset();
    m_ovr = 0; ovr_cnt = 0; max_lvl = 0;
    for (int i = 0; i < 16; i++) send_frame(8'h40 + 8'(i), 1'b1, 1'b0);
    step(4);
    chk("ovr_max_level", max_lvl, DEPTH);
    chk("ovr_seen", ovr_cnt > 0, 1);
    chk("ovr_count_vs_model", ovr_cnt, m_ovr);

    // Reset during data bit 4, then a clean byte.
    fork
      send_frame(8'hF0, 1'b1, 1'b0);
      begin
        step(BAUD * 5 + 8);
        rst_n = 1'b0;
        #1;
        rst_check();
      end
    join
    step(3);
    rst_check();
    rst_n = 1'b1;
    s0 = stb_log.size();
    send_frame(8'h5A, 1'b1, 1'b0);
    chk("mfr_level_after_5a", o_level, 1);
    send_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'h02, 1'b1, 1'b0);
    send_frame(8'h03, 1'b1, 1'b0);
    for (int t = 0; t < 2000 && stb_log.size() == s0; t++) step(1);
    chk("mfr_stb_seen", stb_log.size() > s0, 1);
    if (stb_log.size() > s0) chk("mfr_first_byte", stb_log[s0], 8'h5A);

    // Randomized traffic against the model.
    for (int n = 0; n < 24; n++) begin
      step($urandom_range(0, 300));
      case ($urandom_range(0, 9))
        0:       send_frame(8'($urandom), 1'b0, 1'b0);
        1:       glitch();
        2:       send_frame(8'($urandom), 1'b1, PAR);
        default: send_frame(8'($urandom), 1'b1, 1'b0);
      endcase
    end
    step(2000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
